// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the tiny16 core.
// Fetches a 16-bit instruction from memory at PC (gpr[0]), decodes it and drives
// the register-file selects/strobes, the memory strobes and the ALU op.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   run                start/restart pulse, only honoured while stopped
//   mem_addr/rd/wr     memory request; strobes held until mem_ready
//   mem_wdata          store data (register dst operand)
//   mem_rdata/ready    memory response; mem_ready completes the access this cycle
//   reg_src_sel/dst    register file read selects
//   reg_in_en/reg_in   register file write strobe and data
//   reg_pc_inc         one-cycle PC increment strobe
//   reg_src/reg_dst    register file read data
//   alu_op/alu_result  ALU function (ir[2:0]) and its combinational result
//   halted             high while stopped
//   bus_err            sticky memory-timeout flag, cleared by run
//
// Strobes and selects are decoded from the registered state in the same cycle
// (mem_ready completes accesses combinationally), so an asynchronous reset
// drops them immediately.
module control_unit #(
  parameter int unsigned TIMEOUT = 8,
  parameter logic [3:0]  HLT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [2:0]  reg_src_sel,
  output logic [2:0]  reg_dst_sel,
  output logic        reg_in_en,
  output logic [15:0] reg_in,
  output logic        reg_pc_inc,
  input  logic [15:0] reg_src,
  input  logic [15:0] reg_dst,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        halted,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ALU = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;

  typedef enum logic [2:0] {
    S_STOP   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [8:0] imm9;

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:9];
  assign rs      = ir_q[8:6];
  assign imm9    = ir_q[8:0];
  assign alu_op  = ir_q[2:0];
  assign bus_err = bus_err_q;

  // State, instruction, wait counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_STOP;
      ir_q      <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    reg_src_sel = '0;
    reg_dst_sel = '0;
    reg_in_en   = 1'b0;
    reg_in      = '0;
    reg_pc_inc  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_STOP: begin
        halted = 1'b1;
        if (run) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b0;
          cnt_d     = '0;
        end
      end

      S_FETCH: begin
        // src select 0 reads PC onto reg_src
        mem_addr = reg_src;
        mem_rd   = 1'b1;
        if (mem_ready) begin
          ir_d       = mem_rdata;
          reg_pc_inc = 1'b1;
          state_d    = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        reg_src_sel = rs;
        reg_dst_sel = rd;
        if (op == HLT_OP) begin
          state_d = S_STOP;
        end else if (op == OP_LD || op == OP_ST) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        reg_src_sel = rs;
        reg_dst_sel = rd;
        case (op)
          OP_MOV: begin
            reg_in_en = 1'b1;
            reg_in    = reg_src;
          end
          OP_LDI: begin
            reg_in_en = 1'b1;
            reg_in    = {7'b0, imm9};
          end
          OP_ALU: begin
            reg_in_en = 1'b1;
            reg_in    = alu_result;
          end
          OP_JMP: begin
            // jump is a write of rs into gpr0
            reg_dst_sel = 3'd0;
            reg_in_en   = 1'b1;
            reg_in      = reg_src;
          end
          default: ;
        endcase
        state_d = S_FETCH;
        cnt_d   = '0;
      end

      S_MEM: begin
        reg_src_sel = rs;
        reg_dst_sel = rd;
        mem_addr    = reg_src;
        if (op == OP_LD) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            reg_in_en = 1'b1;
            reg_in    = mem_rdata;
          end
        end else begin
          mem_wr    = 1'b1;
          mem_wdata = reg_dst;
        end
        if (mem_ready) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_STOP;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit. The bench provides the
// register file, ALU and a scripted-latency memory, and an instruction-level
// reference model that expands each program into its expected per-cycle trace.
module tb_control_unit;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;
  logic [2:0]  reg_src_sel, reg_dst_sel, alu_op;
  logic        reg_in_en, reg_pc_inc, halted, bus_err;
  logic [15:0] reg_in, reg_src, reg_dst, alu_result;

  always #5 clk = ~clk;

  control_unit #(.TIMEOUT(TIMEOUT), .HLT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .reg_src_sel(reg_src_sel), .reg_dst_sel(reg_dst_sel),
    .reg_in_en(reg_in_en), .reg_in(reg_in), .reg_pc_inc(reg_pc_inc),
    .reg_src(reg_src), .reg_dst(reg_dst),
    .alu_op(alu_op), .alu_result(alu_result),
    .halted(halted), .bus_err(bus_err)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = a & b;
      3'd3: alu_f = a | b;
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = ~a;
      3'd6: alu_f = a << 1;
      default: alu_f = a >> 1;
    endcase
  endfunction

  // Environment: register file, ALU, memory with scripted wait states.
  logic [15:0] gpr   [0:7];
  logic [15:0] mem_e [0:1023];
  int          env_wait = 0;
  int          e_waits[$];

  assign reg_src    = gpr[reg_src_sel];
  assign reg_dst    = gpr[reg_dst_sel];
  assign alu_result = alu_f(alu_op, reg_dst, reg_src);
  assign mem_rdata  = mem_e[mem_addr[9:0]];
  assign mem_ready  = (mem_rd || mem_wr) && (env_wait == 0);

  // Environment updates observed at negedge, applied just after the next posedge.
  logic        p_we = 1'b0, p_inc = 1'b0, p_mwe = 1'b0;
  logic [2:0]  p_idx = 3'd0;
  logic [15:0] p_val = 16'h0, p_addr = 16'h0, p_wdata = 16'h0;
  int          p_wait = 0;

  // Reference model state.
  typedef struct packed {
    logic        h, b, rd, wr, inc, en;
    logic [2:0]  dst;
    logic [15:0] addr, wdata, val;
  } exp_t;

  logic [15:0] m_reg [0:7];
  logic [15:0] m_mem [0:1023];
  int          m_waits[$];
  exp_t        exp_q[$];

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   rd_cycles, in_en_cnt, in_en_cyc, pc_inc_cyc;
  logic saw40;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic b, input logic r, input logic w,
                              input logic inc, input logic en, input logic [2:0] dst,
                              input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] val);
    exp_t e;
    e.h = h; e.b = b; e.rd = r; e.wr = w; e.inc = inc; e.en = en;
    e.dst = dst; e.addr = addr; e.wdata = wd; e.val = val;
    return e;
  endfunction

  function automatic int pop_m();
    if (m_waits.size() > 0) return m_waits.pop_front();
    return 0;
  endfunction

  function automatic int pop_e();
    if (e_waits.size() > 0) return e_waits.pop_front();
    return 0;
  endfunction

  // Instruction-level model: executes the program and emits one record per cycle.
  task automatic gen_trace();
    int w;
    logic [15:0] pc, ir, a, v;
    logic [3:0] op;
    logic [2:0] rd, rs;
    logic is_ld;
    for (int n = 0; n < 64; n++) begin
      pc = m_reg[0];
      w = pop_m();
      if (w >= int'(TIMEOUT)) begin
        repeat (TIMEOUT) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, pc, 16'h0, 16'h0));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0));
        return;
      end
      repeat (w) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, pc, 16'h0, 16'h0));
      exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 3'd0, pc, 16'h0, 16'h0));
      ir = m_mem[pc[9:0]];
      m_reg[0] = pc + 16'd1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0));
      op = ir[15:12]; rd = ir[11:9]; rs = ir[8:6];
      if (op == 4'hF) begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0));
        return;
      end
      if (op == 4'd4 || op == 4'd5) begin
        is_ld = (op == 4'd4);
        a = m_reg[rs];
        w = pop_m();
        if (w >= int'(TIMEOUT)) begin
          repeat (TIMEOUT) exp_q.push_back(mk(0, 0, is_ld, !is_ld, 0, 0, 3'd0, a, m_reg[rd], 16'h0));
          exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0));
          return;
        end
        repeat (w) exp_q.push_back(mk(0, 0, is_ld, !is_ld, 0, 0, 3'd0, a, m_reg[rd], 16'h0));
        if (is_ld) begin
          exp_q.push_back(mk(0, 0, 1, 0, 0, 1, rd, a, 16'h0, m_mem[a[9:0]]));
          m_reg[rd] = m_mem[a[9:0]];
        end else begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 3'd0, a, m_reg[rd], 16'h0));
          m_mem[a[9:0]] = m_reg[rd];
        end
      end else if (op == 4'd1 || op == 4'd2 || op == 4'd3) begin
        if (op == 4'd1)      v = m_reg[rs];
        else if (op == 4'd2) v = {7'b0, ir[8:0]};
        else                 v = alu_f(ir[2:0], m_reg[rd], m_reg[rs]);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, rd, 16'h0, 16'h0, v));
        m_reg[rd] = v;
      end else if (op == 4'd6) begin
        v = m_reg[rs];
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 3'd0, 16'h0, 16'h0, v));
        m_reg[0] = v;
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0));
      end
    end
  endtask

  task automatic compare(input exp_t e);
    chk("halted", 16'(halted), 16'(e.h));
    chk("bus_err", 16'(bus_err), 16'(e.b));
    chk("mem_rd", 16'(mem_rd), 16'(e.rd));
    chk("mem_wr", 16'(mem_wr), 16'(e.wr));
    chk("pc_inc", 16'(reg_pc_inc), 16'(e.inc));
    chk("reg_in_en", 16'(reg_in_en), 16'(e.en));
    chk("pc_inc_with_in_en", 16'(reg_pc_inc & reg_in_en), 16'h0);
    if (e.rd || e.wr) chk("mem_addr", mem_addr, e.addr);
    if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
    if (e.en) begin
      chk("reg_dst_sel", 16'(reg_dst_sel), 16'(e.dst));
      chk("reg_in", reg_in, e.val);
    end
  endtask

  task automatic apply_pending();
    if (p_we) gpr[p_idx] = p_val;
    if (p_inc) gpr[0] = gpr[0] + 16'd1;
    if (p_mwe) mem_e[p_addr[9:0]] = p_wdata;
    env_wait = p_wait;
    p_we = 1'b0; p_inc = 1'b0; p_mwe = 1'b0;
  endtask

  task automatic env_eval();
    p_we = reg_in_en; p_idx = reg_dst_sel; p_val = reg_in; p_inc = reg_pc_inc;
    p_mwe = 1'b0;
    p_wait = env_wait;
    if (mem_rd || mem_wr) begin
      if (mem_ready) begin
        p_mwe = mem_wr; p_addr = mem_addr; p_wdata = mem_wdata;
        p_wait = pop_e();
      end else begin
        p_wait = env_wait - 1;
      end
    end
    if (mem_rd) rd_cycles++;
    if (mem_rd && mem_addr == 16'h0040) saw40 = 1'b1;
    if (reg_in_en) begin in_en_cnt++; in_en_cyc = cyc; end
    if (reg_pc_inc && pc_inc_cyc < 0) pc_inc_cyc = cyc;
  endtask

  task automatic step();
    @(posedge clk);
    #1 apply_pending();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_wait(input int w);
    env_wait = w;
    p_wait = w;
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    gpr[i] = v; m_reg[i] = v;
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] d);
    mem_e[a[9:0]] = d; m_mem[a[9:0]] = d;
  endtask

  task automatic add_wait(input int w);
    e_waits.push_back(w); m_waits.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    p_we = 1'b0; p_inc = 1'b0; p_mwe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_halted", 16'(halted), 16'h1);
    chk("rst_bus_err", 16'(bus_err), 16'h0);
    chk("rst_strobes", 16'({mem_rd, mem_wr, reg_in_en, reg_pc_inc}), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_selects", 16'({reg_src_sel, reg_dst_sel}), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin gpr[i] = 16'h0; m_reg[i] = 16'h0; end
    for (int i = 0; i < 1024; i++) begin mem_e[i] = 16'h0; m_mem[i] = 16'h0; end
    e_waits.delete(); m_waits.delete(); exp_q.delete();
    set_wait(0);
  endtask

  // Pulse run and check every cycle against the model until it reaches STOP.
  task automatic run_trace(input int budget);
    gen_trace();
    chk("halted_before_run", 16'(halted), 16'h1);
    set_wait(pop_e());
    cyc = 0; rd_cycles = 0; in_en_cnt = 0; in_en_cyc = -1; pc_inc_cyc = -1; saw40 = 1'b0;
    run = 1'b1;
    for (int n = 0; n < budget && exp_q.size() > 0; n++) begin
      step();
      run = 1'b0;
      compare(exp_q.pop_front());
      env_eval();
    end
    run = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL trace_budget: %0d expected cycles not reached", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int hits;

    // LDI r5,0x005 then HLT, zero-wait
    do_reset();
    put(16'h0000, 16'h2A05); put(16'h0001, 16'hF000);
    add_wait(0); add_wait(0);
    run_trace(50);
    chk("ldi_pc_inc_cycle", 16'(pc_inc_cyc), 16'd1);
    chk("ldi_write_cycle", 16'(in_en_cyc), 16'd3);
    chk("ldi_r5", gpr[5], 16'h0005);
    chk("ldi_pc", gpr[0], 16'h0002);

    // LD r2,[r3] with 3 wait cycles on the data read
    do_reset();
    set_reg(3, 16'h0100);
    put(16'h0000, 16'h44C0); put(16'h0001, 16'hF000); put(16'h0100, 16'hBEEF);
    add_wait(0); add_wait(3); add_wait(0);
    run_trace(50);
    chk("ld_rd_cycles", 16'(rd_cycles), 16'd6);
    chk("ld_in_en_count", 16'(in_en_cnt), 16'd1);
    chk("ld_r2", gpr[2], 16'hBEEF);

    // ST r4,[r1]
    do_reset();
    set_reg(1, 16'h00FF); set_reg(4, 16'h1234);
    put(16'h0000, 16'h5840); put(16'h0001, 16'hF000);
    add_wait(0); add_wait(1); add_wait(0);
    run_trace(50);
    chk("st_mem", mem_e[10'h0FF], 16'h1234);
    chk("st_in_en_count", 16'(in_en_cnt), 16'd0);

    // JMP r6
    do_reset();
    set_reg(6, 16'h0040);
    put(16'h0000, 16'h6180); put(16'h0040, 16'hF000);
    add_wait(0); add_wait(0);
    run_trace(50);
    chk("jmp_fetch_0040", 16'(saw40), 16'h1);
    chk("jmp_pc", gpr[0], 16'h0041);

    // MOV, ALU add, NOPs, LD into PC, ALU sub/shl with assorted waits
    do_reset();
    set_reg(2, 16'h0007); set_reg(3, 16'h0010);
    put(16'h0000, 16'h1280); put(16'h0001, 16'h3280); put(16'h0002, 16'h0000);
    put(16'h0003, 16'h7000); put(16'h0004, 16'h40C0); put(16'h0010, 16'h0020);
    put(16'h0020, 16'h3281); put(16'h0021, 16'h3286); put(16'h0022, 16'hF000);
    add_wait(1); add_wait(0); add_wait(2); add_wait(0); add_wait(1);
    add_wait(2); add_wait(0); add_wait(1); add_wait(0);
    run_trace(100);
    chk("mix_r1", gpr[1], 16'h000E);
    chk("mix_pc", gpr[0], 16'h0023);

    // Fetch timeout, then run clears bus_err and resumes at the same PC
    do_reset();
    put(16'h0000, 16'h2203); put(16'h0001, 16'hF000);
    add_wait(0); add_wait(100);
    run_trace(50);
    chk("to_bus_err", 16'(bus_err), 16'h1);
    chk("to_halted", 16'(halted), 16'h1);
    chk("to_rd_cycles", 16'(rd_cycles), 16'd9);
    chk("to_pc_no_inc", gpr[0], 16'h0001);
    chk("to_r1", gpr[1], 16'h0003);
    add_wait(0);
    run_trace(50);
    chk("rerun_bus_err", 16'(bus_err), 16'h0);
    chk("rerun_pc", gpr[0], 16'h0002);

    // Reset during a LD wait abandons the access
    do_reset();
    set_reg(3, 16'h0100); set_reg(2, 16'h1111);
    put(16'h0000, 16'h44C0); put(16'h0100, 16'hBEEF);
    add_wait(0); add_wait(50);
    set_wait(pop_e());
    cyc = 0; hits = 0;
    run = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      run = 1'b0;
      env_eval();
      if (mem_rd && mem_addr == 16'h0100) hits++;
      if (hits == 2) break;
    end
    run = 1'b0;
    chk("mid_mem_reached", 16'(hits), 16'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", 16'({mem_rd, mem_wr, reg_in_en, reg_pc_inc}), 16'h0);
    chk("rst_mid_halted", 16'(halted), 16'h1);
    chk("rst_mid_addr", mem_addr, 16'h0);
    p_we = 1'b0; p_inc = 1'b0; p_mwe = 1'b0; p_wait = env_wait;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    chk("rst_mid_r2_kept", gpr[2], 16'h1111);
    chk("rst_mid_stays_stop", 16'(halted), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
